// File: rtl/scfifo_ctrl.sv
// scfifo_ctrl: single-clock FIFO controller driving a simple dual-port RAM (write port + registered read port).
// Optional `SCFIFO_ERR_FLAGS_EN adds sticky overflow_o/underflow_o outputs.
module scfifo_ctrl #(
  parameter int DWIDTH          = 64,
  parameter int AWIDTH          = 10,
  parameter int REGISTER_OUTPUT = 0,
  parameter int ALMOST_FULL     = 2**AWIDTH-4,
  parameter int ALMOST_EMPTY    = 4
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              q_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic [DWIDTH-1:0] ram_data_o,
  output logic [AWIDTH-1:0] ram_wr_addr_o,
  output logic [AWIDTH-1:0] ram_rd_addr_o,
  output logic              ram_wr_en_o,
  output logic              ram_rd_en_o,
`ifdef SCFIFO_ERR_FLAGS_EN
  output logic              overflow_o,
  output logic              underflow_o,
`endif
  input  logic [DWIDTH-1:0] ram_data_i
);
  localparam int LAT = 1 + REGISTER_OUTPUT;
  localparam logic [AWIDTH:0] DEPTH = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AF = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE = (AWIDTH+1)'(ALMOST_EMPTY);
  logic [AWIDTH-1:0] wr_ptr, rd_ptr;
  logic [AWIDTH:0]   usedw_nxt;
  logic [LAT-1:0]    vld;
  logic              push, pop;
  always_comb begin
    push      = wrreq_i && !full_o;
    pop       = rdreq_i && !empty_o;
    usedw_nxt = usedw_o + (AWIDTH+1)'(push) - (AWIDTH+1)'(pop);
  end
  assign ram_wr_en_o   = push;
  assign ram_rd_en_o   = pop;
  assign ram_wr_addr_o = wr_ptr;
  assign ram_rd_addr_o = rd_ptr;
  assign ram_data_o    = data_i;
  assign q_o           = ram_data_i;
  assign q_valid_o     = vld[LAT-1];
  // Flags are derived from the next count so they land together with usedw_o.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      usedw_o        <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= (ALMOST_FULL == 0);
      vld            <= '0;
    end else begin
      wr_ptr         <= wr_ptr + AWIDTH'(push);
      rd_ptr         <= rd_ptr + AWIDTH'(pop);
      usedw_o        <= usedw_nxt;
      empty_o        <= usedw_nxt == '0;
      full_o         <= usedw_nxt == DEPTH;
      almost_empty_o <= usedw_nxt < AE;
      almost_full_o  <= usedw_nxt >= AF;
      vld            <= (vld << 1) | LAT'(pop);
    end
  end
`ifdef SCFIFO_ERR_FLAGS_EN
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= overflow_o  | (wrreq_i && full_o);
      underflow_o <= underflow_o | (rdreq_i && empty_o);
    end
  end
`endif
endmodule
